sulba_hypot_engine: RTL and testbench

SULBA_HYPOT_ENGINE -- requirements
Module: sulba_hypot_engine

---
 rtl/sulba_pkg.sv | 28 ++
 rtl/sulba_isqrt.sv | 74 +++++++
 rtl/sulba_hypot_engine.sv | 157 +++++++++++++++
 tb/tb_sulba_hypot_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sulba_pkg.sv
// Shared definitions for the sulba hypotenuse/square-root engine: op codes,
// FSM states and width helpers.
package sulba_pkg;

    typedef enum logic [1:0] {
        OP_SQRT  = 2'd0,
        OP_HYPOT = 2'd1,
        OP_DIFF  = 2'd2,
        OP_RECT  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        HOLD = 3'd3,
        VERT = 3'd4
    } state_e;

    function automatic int unsigned root_w(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned rad_w(input int unsigned w);
        return 2 * w + 2;
    endfunction

endpackage

// File: rtl/sulba_isqrt.sv
// Restoring digit-by-digit integer square root, one root bit per cycle, MSB first.
// The first digit is resolved on the start edge so done lands W+1 edges after start.
module sulba_isqrt
    import sulba_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [rad_w(W)-1:0]    radicand,
    output logic                   done,
    output logic [root_w(W)-1:0]   root,
    output logic [W+1:0]           rem
);

    localparam int unsigned RW   = root_w(W);
    localparam int unsigned RADW = rad_w(W);
    localparam int unsigned CW   = $clog2(RW + 1);

    logic [RADW-1:0] rad_q;
    logic [W+1:0]    rem_q;
    logic [RW-1:0]   root_q;
    logic [CW-1:0]   cnt_q;

    logic [RADW-1:0] src_rad;
    logic [W+1:0]    src_rem;
    logic [RW-1:0]   src_root;
    logic [W+3:0]    acc;
    logic [W+2:0]    trial;
    logic            ge;
    logic [W+1:0]    nrem;
    logic [RW-1:0]   nroot;

    always_comb begin
        src_rad  = start ? radicand : rad_q;
        src_rem  = start ? '0 : rem_q;
        src_root = start ? '0 : root_q;
        acc      = {src_rem, src_rad[RADW-1 -: 2]};
        trial    = {src_root, 2'b01};
        ge       = (acc >= {1'b0, trial});
        nrem     = (W+2)'(ge ? acc - {1'b0, trial} : acc);
        nroot    = {src_root[RW-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rad_q  <= src_rad << 2;
                rem_q  <= nrem;
                root_q <= nroot;
                cnt_q  <= CW'(W);
            end else if (cnt_q != '0) begin
                rad_q  <= rad_q << 2;
                rem_q  <= nrem;
                root_q <= nroot;
                cnt_q  <= cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    done <= 1'b1;
            end
        end
    end

    assign root = root_q;
    assign rem  = rem_q;

endmodule

// File: rtl/sulba_hypot_engine.sv
// Command-driven fixed-point sqrt / hypot / difference-root engine with a
// rectangle vertex emitter; one command in flight, results held until taken.
module sulba_hypot_engine
    import sulba_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [root_w(W)-1:0]  root,
    output logic [rad_w(W)-1:0]   sq,
    output logic [W-1:0]          out_x,
    output logic [W-1:0]          out_y,
    output logic                  exact,
    output logic                  err,
    output logic                  last,
    output logic                  busy
);

    localparam int unsigned RW   = root_w(W);
    localparam int unsigned RADW = rad_w(W);

    state_e          state_q;
    op_e             op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [1:0]      beat_q;
    logic [1:0]      beat_nx;

    logic [RADW-1:0] radicand;
    logic            diff_err;
    logic            isq_start;
    logic            isq_done;
    logic [RW-1:0]   isq_root;
    logic [W+1:0]    isq_rem;

    always_comb begin
        radicand = '0;
        diff_err = 1'b0;
        case (op_q)
            OP_SQRT:  radicand = RADW'(a_q) << FRAC;
            OP_HYPOT: radicand = RADW'(a_q) * RADW'(a_q) + RADW'(b_q) * RADW'(b_q);
            OP_DIFF: begin
                diff_err = (b_q > a_q);
                radicand = RADW'(a_q) * RADW'(a_q) - RADW'(b_q) * RADW'(b_q);
            end
            default: radicand = '0;
        endcase
    end

    assign isq_start = (state_q == LOAD) && !diff_err;
    assign beat_nx   = beat_q + 2'd1;

    sulba_isqrt #(.W(W)) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (isq_start),
        .radicand (radicand),
        .done     (isq_done),
        .root     (isq_root),
        .rem      (isq_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_SQRT;
            a_q       <= '0;
            b_q       <= '0;
            beat_q    <= '0;
            out_valid <= 1'b0;
            root      <= '0;
            sq        <= '0;
            out_x     <= '0;
            out_y     <= '0;
            exact     <= 1'b0;
            err       <= 1'b0;
            last      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q   <= op_e'(op);
                    a_q    <= a;
                    b_q    <= b;
                    err    <= 1'b0;
                    exact  <= 1'b0;
                    last   <= 1'b0;
                    beat_q <= '0;
                    if (op_e'(op) == OP_RECT) begin
                        state_q   <= VERT;
                        out_valid <= 1'b1;
                        out_x     <= '0;
                        out_y     <= '0;
                        root      <= '0;
                        sq        <= RADW'(a) * RADW'(b);
                    end else begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    out_x <= '0;
                    out_y <= '0;
                    if (diff_err) begin
                        // Error result is staged here; HOLD raises out_valid one edge later.
                        state_q <= HOLD;
                        err     <= 1'b1;
                        root    <= '0;
                        sq      <= '0;
                        exact   <= 1'b0;
                    end else begin
                        state_q <= ITER;
                        sq      <= radicand;
                    end
                end
                ITER: if (isq_done) begin
                    state_q   <= HOLD;
                    out_valid <= 1'b1;
                    root      <= isq_root;
                    exact     <= (isq_rem == '0);
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        state_q   <= IDLE;
                        out_valid <= 1'b0;
                    end else if (!out_valid) begin
                        out_valid <= 1'b1;
                    end
                end
                VERT: if (out_ready) begin
                    if (beat_q == 2'd3) begin
                        state_q   <= IDLE;
                        out_valid <= 1'b0;
                        last      <= 1'b0;
                    end else begin
                        beat_q <= beat_nx;
                        out_x  <= (beat_nx == 2'd3) ? '0 : a_q;
                        out_y  <= (beat_nx == 2'd1) ? '0 : b_q;
                        last   <= (beat_nx == 2'd3);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sulba_hypot_engine.sv
// Directed self-checking bench for sulba_hypot_engine (W=16, FRAC=8).
module tb_sulba_hypot_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] root;
    logic [33:0] sq;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic        exact;
    logic        err;
    logic        last;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    sulba_hypot_engine #(.W(16), .FRAC(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root      (root),
        .sq        (sq),
        .out_x     (out_x),
        .out_y     (out_y),
        .exact     (exact),
        .err       (err),
        .last      (last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb);
        op       = o;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_root"},  root,      0);
        chk({tag, "_sq"},    sq,        0);
        chk({tag, "_x"},     out_x,     0);
        chk({tag, "_y"},     out_y,     0);
        chk({tag, "_exact"}, exact,     0);
        chk({tag, "_err"},   err,       0);
        chk({tag, "_last"},  last,      0);
    endtask

    initial begin
        int n;
        int saw_valid;
        logic [15:0] vx [4];
        logic [15:0] vy [4];
        vx = '{16'd0, 16'd5, 16'd5, 16'd0};
        vy = '{16'd0, 16'd0, 16'd3, 16'd3};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'd0; a = '0; b = '0;
        repeat (2) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("reset_in_ready", in_ready, 1);

        // SQRT 2.0 in Q8.8
        issue(2'd0, 16'h0200, 16'h0000);
        chk("sqrt_busy", busy, 1);
        wait_valid(n);
        chk("sqrt_latency", n, 18);
        chk("sqrt_root", root, 17'h016A);
        chk("sqrt_exact", exact, 0);
        chk("sqrt_err", err, 0);
        chk("sqrt_sq", sq, 34'h20000);
        take();
        chk("sqrt_done_valid", out_valid, 0);
        chk("sqrt_done_ready", in_ready, 1);

        issue(2'd1, 16'h0300, 16'h0400);
        wait_valid(n);
        chk("hypot_latency", n, 18);
        chk("hypot_sq", sq, 34'd1638400);
        chk("hypot_root", root, 17'h0500);
        chk("hypot_exact", exact, 1);
        take();

        issue(2'd2, 16'h0500, 16'h0400);
        wait_valid(n);
        chk("diff_latency", n, 18);
        chk("diff_root", root, 17'h0300);
        chk("diff_exact", exact, 1);
        chk("diff_err", err, 0);
        chk("diff_sq", sq, 34'd589824);
        take();

        issue(2'd2, 16'd3, 16'd4);
        wait_valid(n);
        chk("differr_latency", n, 2);
        chk("differr_err", err, 1);
        chk("differr_root", root, 0);
        chk("differr_sq", sq, 0);
        chk("differr_exact", exact, 0);
        take();
        chk("differr_idle", in_ready, 1);

        issue(2'd0, 16'd0, 16'd0);
        wait_valid(n);
        chk("sqrt0_root", root, 0);
        chk("sqrt0_exact", exact, 1);
        take();

        issue(2'd3, 16'd5, 16'd3);
        wait_valid(n);
        chk("rect_valid", out_valid, 1);
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b0;
            tick();
            chk($sformatf("rect%0d_stall_valid", k), out_valid, 1);
            chk($sformatf("rect%0d_x", k), out_x, vx[k]);
            chk($sformatf("rect%0d_y", k), out_y, vy[k]);
            chk($sformatf("rect%0d_sq", k), sq, 15);
            chk($sformatf("rect%0d_root", k), root, 0);
            chk($sformatf("rect%0d_last", k), last, (k == 3) ? 1 : 0);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk("rect_end_valid", out_valid, 0);
        chk("rect_end_ready", in_ready, 1);

        // Result held under back-pressure; commands arriving meanwhile are dropped
        issue(2'd1, 16'd6, 16'd8);
        wait_valid(n);
        op = 2'd0; a = 16'h0100; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("hold%0d_valid", k), out_valid, 1);
            chk($sformatf("hold%0d_root", k), root, 10);
            chk($sformatf("hold%0d_sq", k), sq, 100);
            chk($sformatf("hold%0d_in_ready", k), in_ready, 0);
        end
        in_valid = 1'b0;
        take();
        chk("hold_release_valid", out_valid, 0);
        chk("hold_release_ready", in_ready, 1);
        tick();
        chk("hold_no_capture", busy, 0);

        // Reset in the middle of the iteration
        issue(2'd0, 16'h0900, 16'h0000);
        repeat (6) tick();
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        #2;
        rst_n = 1'b1;
        saw_valid = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid === 1'b1) saw_valid = 1;
        end
        chk("abort_no_valid", saw_valid, 0);
        chk("abort_ready", in_ready, 1);

        issue(2'd0, 16'h0400, 16'h0000);
        wait_valid(n);
        chk("post_latency", n, 18);
        chk("post_root", root, 17'h0200);
        chk("post_exact", exact, 1);
        take();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
